// File: rtl/traffic_pkg.sv
// Shared types and default timing for the jam-mode phase arbiter.
package traffic_pkg;

  localparam int unsigned NUM_ROADS = 4;
  localparam int unsigned ROAD_W    = 2;

  localparam int unsigned DEF_GREEN_MIN    = 4;
  localparam int unsigned DEF_GREEN_MAX    = 8;
  localparam int unsigned DEF_CLEAR_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    GREEN
  } state_t;

  function automatic logic [NUM_ROADS-1:0] onehot(input logic [ROAD_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/jam_phase_arbiter_if.sv
// Control-unit side request/enable and arbiter green-pattern outputs.
interface jam_phase_arbiter_if;
  import traffic_pkg::*;

  logic                 en;
  logic [NUM_ROADS-1:0] jam_req;
  logic [NUM_ROADS-1:0] allow;
  logic [ROAD_W-1:0]    grant_idx;
  logic                 clearing;
  logic                 phase_done;

  modport master (
    output en, jam_req,
    input  allow, grant_idx, clearing, phase_done
  );

  modport slave (
    input  en, jam_req,
    output allow, grant_idx, clearing, phase_done
  );

endinterface

// File: rtl/jam_rr_picker.sv
// Rotating-priority search: last+1 first, wrapping, with last itself considered last.
module jam_rr_picker
  import traffic_pkg::*;
(
  input  logic [NUM_ROADS-1:0] req,
  input  logic [ROAD_W-1:0]    last,
  output logic                 valid,
  output logic [ROAD_W-1:0]    idx
);

  logic [ROAD_W-1:0] cand;

  // Walk from lowest to highest priority so the highest-priority hit overwrites.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_ROADS; k++) begin
      cand = last + ROAD_W'(NUM_ROADS - k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/jam_phase_arbiter.sv
// Round-robin jam-mode green arbiter with min/max green and all-red clearance.
module jam_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MIN    = DEF_GREEN_MIN,
  parameter int unsigned GREEN_MAX    = DEF_GREEN_MAX,
  parameter int unsigned CLEAR_CYCLES = DEF_CLEAR_CYCLES,
  parameter int unsigned CNT_W        = 8
) (
  input logic               clk,
  input logic               rst_n,
  jam_phase_arbiter_if.slave bus
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ROAD_W-1:0] last;
  logic              pick_valid;
  logic [ROAD_W-1:0] pick_idx;

  jam_rr_picker u_picker (
    .req   (bus.jam_req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      last           <= ROAD_W'(NUM_ROADS - 1);
      bus.allow      <= '0;
      bus.grant_idx  <= '0;
      bus.clearing   <= 1'b0;
      bus.phase_done <= 1'b0;
    end else begin
      bus.phase_done <= 1'b0;
      // Disable wins over any simultaneous exit; a cut-short green still counts as served.
      if (!bus.en) begin
        if (state == GREEN) last <= bus.grant_idx;
        state        <= IDLE;
        cnt          <= '0;
        bus.allow    <= '0;
        bus.clearing <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (|bus.jam_req) begin
              state        <= CLEAR;
              cnt          <= CNT_W'(1);
              bus.clearing <= 1'b1;
            end
          end
          CLEAR: begin
            if (cnt == CNT_W'(CLEAR_CYCLES)) begin
              bus.clearing <= 1'b0;
              if (pick_valid) begin
                state         <= GREEN;
                cnt           <= CNT_W'(1);
                bus.grant_idx <= pick_idx;
                bus.allow     <= onehot(pick_idx);
              end else begin
                state <= IDLE;
                cnt   <= '0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GREEN: begin
            if (cnt == CNT_W'(GREEN_MAX) ||
                (cnt >= CNT_W'(GREEN_MIN) && !bus.jam_req[bus.grant_idx])) begin
              last           <= bus.grant_idx;
              state          <= CLEAR;
              cnt            <= CNT_W'(1);
              bus.allow      <= '0;
              bus.clearing   <= 1'b1;
              bus.phase_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state        <= IDLE;
            cnt          <= '0;
            bus.allow    <= '0;
            bus.clearing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jam_phase_arbiter.sv
// Directed self-checking bench for jam_phase_arbiter with default timing (4/8/2).
module tb_jam_phase_arbiter;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jam_phase_arbiter_if bus ();

  jam_phase_arbiter #(
    .GREEN_MIN    (4),
    .GREEN_MAX    (8),
    .CLEAR_CYCLES (2),
    .CNT_W        (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] a, input logic [1:0] g,
                            input logic c, input logic p);
    check(tag, {bus.allow, bus.grant_idx, bus.clearing, bus.phase_done}, {a, g, c, p});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.en      = 1'b0;
    bus.jam_req = 4'b0000;
    rst_n       = 1'b0;
    tick();
    #2;
    rst_n = 1'b1;
  endtask

  logic [3:0] ea;
  logic [1:0] eg;
  logic       ec, ep;
  int         p, s;

  initial begin
    bus.en      = 1'b0;
    bus.jam_req = 4'b0000;
    rst_n       = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    expect_out("reset_init", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single persistent jam on road 2
    bus.jam_req = 4'b0100;
    bus.en      = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      ec = (k == 1 || k == 2 || k == 11 || k == 12);
      ep = (k == 11);
      ea = ((k >= 3 && k <= 10) || k >= 13) ? 4'b0100 : 4'b0000;
      eg = (k >= 3) ? 2'd2 : 2'd0;
      expect_out($sformatf("single_c%0d", k), ea, eg, ec, ep);
    end

    // Asynchronous reset while green
    rst_n = 1'b0;
    #1;
    check("reset_async_allow", {4'b0000, bus.allow}, 8'h00);
    bus.en      = 1'b0;
    bus.jam_req = 4'b0000;
    tick();
    #2;
    rst_n = 1'b1;
    expect_out("reset_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("reset_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // All roads jammed: 0,1,2,3,0 each 8 cycles with 2 red cycles between
    bus.jam_req = 4'b1111;
    bus.en      = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      p = (k - 1) % 10;
      s = (k - 1) / 10;
      if (p < 2) begin
        ea = 4'b0000;
        ec = 1'b1;
        eg = (s == 0) ? 2'd0 : 2'((s - 1) % 4);
        ep = (p == 0 && s > 0);
      end else begin
        eg = 2'(s % 4);
        ea = 4'b0001 << eg;
        ec = 1'b0;
        ep = 1'b0;
      end
      expect_out($sformatf("all_c%0d", k), ea, eg, ec, ep);
    end

    // Early release of road 1, then road 3 next
    do_reset();
    bus.jam_req = 4'b0010;
    bus.en      = 1'b1;
    tick(); expect_out("early_c1", 4'b0000, 2'd0, 1'b1, 1'b0);
    tick(); expect_out("early_c2", 4'b0000, 2'd0, 1'b1, 1'b0);
    tick(); expect_out("early_g1", 4'b0010, 2'd1, 1'b0, 1'b0);
    bus.jam_req = 4'b1000;
    tick(); expect_out("early_g2", 4'b0010, 2'd1, 1'b0, 1'b0);
    tick(); expect_out("early_g3", 4'b0010, 2'd1, 1'b0, 1'b0);
    tick(); expect_out("early_g4", 4'b0010, 2'd1, 1'b0, 1'b0);
    tick(); expect_out("early_clr1", 4'b0000, 2'd1, 1'b1, 1'b1);
    tick(); expect_out("early_clr2", 4'b0000, 2'd1, 1'b1, 1'b0);
    tick(); expect_out("early_next", 4'b1000, 2'd3, 1'b0, 1'b0);

    // Disable during green cycle 5 of road 2, then re-enable
    do_reset();
    bus.jam_req = 4'b0100;
    bus.en      = 1'b1;
    repeat (2) tick();
    for (int k = 1; k <= 5; k++) begin
      tick();
      expect_out($sformatf("dis_g%0d", k), 4'b0100, 2'd2, 1'b0, 1'b0);
    end
    bus.en = 1'b0;
    tick(); expect_out("dis_off", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick(); expect_out("dis_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    bus.jam_req = 4'b0101;
    bus.en      = 1'b1;
    tick(); expect_out("reen_c1", 4'b0000, 2'd2, 1'b1, 1'b0);
    tick(); expect_out("reen_c2", 4'b0000, 2'd2, 1'b1, 1'b0);
    tick(); expect_out("reen_grant", 4'b0001, 2'd0, 1'b0, 1'b0);

    // Requests vanish during clearance: back to IDLE, grant_idx kept
    do_reset();
    bus.jam_req = 4'b0100;
    bus.en      = 1'b1;
    repeat (10) tick();
    expect_out("empty_gmax", 4'b0100, 2'd2, 1'b0, 1'b0);
    tick(); expect_out("empty_clr1", 4'b0000, 2'd2, 1'b1, 1'b1);
    bus.jam_req = 4'b0000;
    tick(); expect_out("empty_clr2", 4'b0000, 2'd2, 1'b1, 1'b0);
    tick(); expect_out("empty_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick(); expect_out("empty_stay", 4'b0000, 2'd2, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
